pipelined_adder: RTL and testbench

- Parametrised, pipelined two's-complement add/subtract unit.
- Splits a WIDTH-bit operation into CHUNK-bit slices and resolves one slice per stage, so carry chains stay short at high clock rates.
- Accepts one operation per cycle through a valid/ready handshake and supports output backpressure.
- Sits between an operand producer and a result consumer on the datapath. It is the generalised successor of the team's fixed 8-bit combinational adder.

---
 rtl/adder_pkg.sv | 25 ++
 rtl/adder_stage.sv | 44 ++++
 rtl/pipelined_adder.sv | 110 +++++++++++
 tb/tb_pipelined_adder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for pipelined_adder and its per-slice adder_stage.
// Optional overflow output is controlled by PIPELINED_ADDER_OVF_EN in the top.
package adder_pkg;

  // Widest slice a single stage may resolve; bounds the payload struct below.
  localparam int unsigned MAX_CHUNK = 32;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_mode_e;

  typedef struct packed {
    logic [MAX_CHUNK-1:0] slice_sum;
    logic                 carry;
    logic                 carry_msb;
    logic                 valid;
  } stage_t;

  function automatic int unsigned calc_stages(input int unsigned width,
                                              input int unsigned chunk);
    return (chunk == 0 || chunk > width) ? 1 : width / chunk;
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One CHUNK-bit slice of the pipelined adder: slice sum, carry out and the
// carry into the slice MSB, registered together with the valid bit.
module adder_stage
  import adder_pkg::*;
#(
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_carry,
  input  logic             i_valid,
  output stage_t           o_q
);

  logic [CHUNK:0] w_full;
  stage_t         w_d;
  stage_t         r_q;

  // NOTE: every field gets a default first so no path through the block can infer a latch.
  always_comb begin
    w_d           = '0;
    w_full        = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_carry};
    w_d.slice_sum = MAX_CHUNK'(w_full[CHUNK-1:0]);
    w_d.carry     = w_full[CHUNK];
    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out by XOR.
    w_d.carry_msb = w_full[CHUNK-1] ^ i_a[CHUNK-1] ^ i_b[CHUNK-1];
    w_d.valid     = i_valid;
  end

  // NOTE: state updates use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= w_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipelined_adder.sv
// Skewed-pipeline add/subtract unit resolving CHUNK bits per stage with valid/ready flow control.
// Define PIPELINED_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
`ifdef PIPELINED_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned STAGES = calc_stages(WIDTH, CHUNK);

  if (!(CHUNK >= 1 && CHUNK <= MAX_CHUNK && (WIDTH % CHUNK) == 0)) begin : g_bad_cfg
    $error("pipelined_adder: CHUNK must be 1..%0d and divide WIDTH", MAX_CHUNK);
  end

  logic             w_stall;
  logic             w_en;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_a_in    [STAGES];
  logic [WIDTH-1:0] w_b_in    [STAGES];
  logic [WIDTH-1:0] w_res_in  [STAGES];
  logic [WIDTH-1:0] w_res_out [STAGES];
  logic             w_carry_in[STAGES];
  logic             w_valid_in[STAGES];
  stage_t           w_stage   [STAGES];

  // A result waiting on the consumer freezes the whole pipe, bubbles included.
  assign w_stall  = w_stage[STAGES-1].valid && !out_ready;
  assign w_en     = !w_stall;
  assign in_ready = w_en;
  assign w_b_eff  = (op_mode_e'(sub) == OP_SUB) ? ~b : b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic w_unused_bits;

    if (k == 0) begin : g_head
      assign w_a_in[k]     = a;
      assign w_b_in[k]     = w_b_eff;
      assign w_res_in[k]   = '0;
      assign w_carry_in[k] = c_in;
      assign w_valid_in[k] = in_valid;
    end else begin : g_tail
      // r_a/r_b track the operands alongside stage k-1; r_res tracks the
      // lower result slices alongside stage k.
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;
      logic [WIDTH-1:0] r_res;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a   <= '0;
          r_b   <= '0;
          r_res <= '0;
        end else if (w_en) begin
          r_a   <= w_a_in[k-1];
          r_b   <= w_b_in[k-1];
          r_res <= w_res_out[k-1];
        end
      end

      assign w_a_in[k]     = r_a;
      assign w_b_in[k]     = r_b;
      assign w_res_in[k]   = r_res;
      assign w_carry_in[k] = w_stage[k-1].carry;
      assign w_valid_in[k] = w_stage[k-1].valid;
    end

    adder_stage #(
      .CHUNK(CHUNK)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_en),
      .i_a     (w_a_in[k][k*CHUNK +: CHUNK]),
      .i_b     (w_b_in[k][k*CHUNK +: CHUNK]),
      .i_carry (w_carry_in[k]),
      .i_valid (w_valid_in[k]),
      .o_q     (w_stage[k])
    );

    assign w_res_out[k]  = w_res_in[k]
                         | (WIDTH'(w_stage[k].slice_sum[CHUNK-1:0]) << (k * CHUNK));
    assign w_unused_bits = ^w_stage[k].slice_sum ^ w_stage[k].carry_msb;
  end

  assign sum       = w_res_out[STAGES-1];
  assign c_out     = w_stage[STAGES-1].carry;
  assign out_valid = w_stage[STAGES-1].valid;

`ifdef PIPELINED_ADDER_OVF_EN
  assign ovf = w_stage[STAGES-1].carry_msb ^ w_stage[STAGES-1].carry;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, CHUNK=4) against a
// queue-based arithmetic reference model; honours PIPELINED_ADDER_OVF_EN.
module tb_pipelined_adder;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned CHUNK  = 4;
  localparam int unsigned STAGES = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             out_valid;
  logic             out_ready;
`ifdef PIPELINED_ADDER_OVF_EN
  logic             ovf;
`endif

  pipelined_adder #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .c_out     (c_out),
`ifdef PIPELINED_ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Each accepted op carries its arithmetic result and the number of
  // unstalled edges still needed before it reaches the output.
  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               rem;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                  input logic ci, input logic sb);
    exp_t             r;
    logic [WIDTH-1:0] be;
    logic [WIDTH:0]   t;
    be     = sb ? ~bv : bv;
    t      = {1'b0, av} + {1'b0, be} + {{WIDTH{1'b0}}, ci};
    r.sum  = t[WIDTH-1:0];
    r.cout = t[WIDTH];
    r.ovf  = (av[WIDTH-1] == be[WIDTH-1]) && (t[WIDTH-1] != av[WIDTH-1]);
    r.rem  = STAGES - 1;
    return r;
  endfunction

  // Drive one cycle's inputs, check outputs against the model, advance one clock.
  task automatic step(input logic v, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                      input logic ci, input logic sb, input logic ordy, output logic acc);
    logic exp_valid;
    logic stall;
    in_valid  = v;
    a         = av;
    b         = bv;
    c_in      = ci;
    sub       = sb;
    out_ready = ordy;
    #1;
    exp_valid = (q.size() > 0) && (q[0].rem == 0);
    stall     = exp_valid && !ordy;
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    check("in_ready", 32'(in_ready), 32'(!stall));
    if (exp_valid) begin
      check("sum", 32'(sum), 32'(q[0].sum));
      check("c_out", 32'(c_out), 32'(q[0].cout));
`ifdef PIPELINED_ADDER_OVF_EN
      check("ovf", 32'(ovf), 32'(q[0].ovf));
`endif
    end
    acc = v && !stall;
    if (!stall) begin
      if (exp_valid) void'(q.pop_front());
      foreach (q[i]) if (q[i].rem > 0) q[i].rem--;
      if (acc) q.push_back(ref_op(av, bv, ci, sb));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, ordy, acc);
  endtask

  // Single op with a literal expectation exactly STAGES edges after acceptance.
  task automatic directed(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic ci, input logic sb, input logic [WIDTH-1:0] es,
                          input logic ec, input logic eovf);
    logic acc;
    step(1'b1, av, bv, ci, sb, 1'b1, acc);
    idle(STAGES - 1, 1'b1);
    check({tag, "_valid"}, 32'(out_valid), 32'(1));
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(c_out), 32'(ec));
`ifdef PIPELINED_ADDER_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
`else
    if (eovf !== 1'b0 && eovf !== 1'b1) check({tag, "_ovf_arg"}, 32'(eovf), 32'(0));
`endif
    idle(1, 1'b1);
  endtask

  initial begin
    logic acc;
    logic v;
    logic ordy;
    int   sent;

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    c_in      = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_sum", 32'(sum), 32'(0));
    check("rst_c_out", 32'(c_out), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
`ifdef PIPELINED_ADDER_OVF_EN
    check("rst_ovf", 32'(ovf), 32'(0));
`endif
    rst = 1'b0;
    idle(2, 1'b1);

    directed("add_00ff", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    directed("add_ffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("sub_5_7",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
`ifdef PIPELINED_ADDER_OVF_EN
    directed("ovf_7fff", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
`endif

    // Back-to-back random stream, consumer always ready.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, WIDTH'($urandom()), WIDTH'($urandom()), 1'($urandom()), 1'($urandom()), 1'b1, acc);
      check("stream8_accept", 32'(in_ready === 1'b1 || !acc), 32'(1));
    end
    idle(STAGES, 1'b1);

    // Six ops with a three-cycle stall; the first stall cycle also drops in_valid.
    sent = 0;
    for (int t = 0; t < 40 && (sent < 6 || q.size() > 0); t++) begin
      ordy = !(t >= 4 && t < 7);
      v    = (sent < 6) && (t != 4);
      step(v, WIDTH'($urandom()), WIDTH'($urandom()), 1'($urandom()), 1'($urandom()), ordy, acc);
      if (acc) sent++;
    end
    idle(2, 1'b1);

    // Reset with one result stalled at the output and two more in flight.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, WIDTH'($urandom()), WIDTH'($urandom()), 1'b0, 1'b0, 1'b1, acc);
    end
    idle(1, 1'b0);
    check("pre_rst_out_valid", 32'(out_valid), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'(0));
    check("mid_rst_sum", 32'(sum), 32'(0));
    check("mid_rst_in_ready", 32'(in_ready), 32'(1));
    q.delete();
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(10, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
